seg_reg_bank_agu: RTL



---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_pa_adder.sv | 15 +
 rtl/seg_reg_bank_agu.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared segment indices, reset value and PA width helper (SEG_A20_EN widens PA by one bit)
package seg_pkg;
    localparam int SEG_SEL_W = 2;
    localparam int SEG_CS = 0;
    localparam int SEG_DS = 1;
    localparam int SEG_ES = 2;
    localparam int SEG_SS = 3;
    localparam logic [15:0] SEG_CS_RST = 16'hFFFF;
    // With A20 the carry out of segment*16 + offset is kept as an extra address bit
    function automatic int pa_width(input int seg_w);
`ifdef SEG_A20_EN
        return seg_w + 5;
`else
        return seg_w + 4;
`endif
    endfunction
endpackage

// File: rtl/seg_pa_adder.sv
// seg_pa_adder: combinational segment*16 + offset; result width from pa_width (SEG_A20_EN keeps the carry)
module seg_pa_adder
    import seg_pkg::*;
#(
    parameter int SEG_W = 16,
    parameter int OFF_W = 16
) (
    input  logic [SEG_W-1:0]           i_seg,
    input  logic [OFF_W-1:0]           i_off,
    output logic [pa_width(SEG_W)-1:0] o_pa
);
    localparam int PA_W = pa_width(SEG_W);
    // Both operands zero-extended to PA_W: wraps at 2**(SEG_W+4) unless A20 adds the carry bit
    always_comb o_pa = PA_W'({i_seg, 4'b0}) + PA_W'(i_off);
endmodule

// File: rtl/seg_reg_bank_agu.sv
// seg_reg_bank_agu: segment register bank with write-first read port, override latch, 1-cycle AGU and MOV SS interrupt inhibit (option SEG_A20_EN)
module seg_reg_bank_agu
    import seg_pkg::*;
#(
    parameter int NUM_SEGS = 4,
    parameter int SEL_W = SEG_SEL_W,
    parameter int SEG_W = 16,
    parameter int OFF_W = 16,
    parameter int CS_IDX = SEG_CS,
    parameter int SS_IDX = SEG_SS,
    parameter logic [SEG_W-1:0] CS_RST = SEG_W'(SEG_CS_RST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [SEL_W-1:0]           i_wr_sel,
    input  logic [SEG_W-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    input  logic [SEL_W-1:0]           i_rd_sel,
    output logic [SEG_W-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    input  logic                       i_ovr_set,
    input  logic [SEL_W-1:0]           i_ovr_sel,
    input  logic                       i_inst_bnd,
    input  logic                       i_agu_req,
    input  logic [SEL_W-1:0]           i_agu_sel,
    input  logic                       i_agu_use_ovr,
    input  logic [OFF_W-1:0]           i_agu_off,
    output logic [pa_width(SEG_W)-1:0] o_pa,
    output logic                       o_pa_valid,
    output logic                       o_ovr_active,
    output logic                       o_int_inhibit,
    output logic                       o_sel_err
);
    localparam int PA_W = pa_width(SEG_W);
    localparam int NSEL = 2 ** SEL_W;

    logic [SEG_W-1:0] r_seg [NUM_SEGS];
    logic [SEG_W-1:0] w_seg_ext [NSEL];
    logic [SEG_W-1:0] r_rd_data;
    logic             r_rd_valid;
    logic [PA_W-1:0]  r_pa;
    logic             r_pa_valid;
    logic             r_ovr_active;
    logic [SEL_W-1:0] r_ovr_sel;
    logic [1:0]       r_inh_cnt;
    logic             r_int_inhibit;
    logic             r_sel_err;
    logic             w_wr_ok;
    logic             w_ss_wr;
    logic [SEL_W-1:0] w_agu_sel;
    logic [SEG_W-1:0] w_rd_seg;
    logic [SEG_W-1:0] w_agu_seg;
    logic [PA_W-1:0]  w_pa;
    logic             w_sel_err;
    logic [1:0]       w_cnt_nxt;

    function automatic logic in_rng(input logic [SEL_W-1:0] s);
        return {1'b0, s} < (SEL_W + 1)'(NUM_SEGS);
    endfunction

    // Pad the bank to the full select space so unimplemented indices read as zero
    for (genvar g = 0; g < NSEL; g++) begin : g_ext
        if (g < NUM_SEGS) begin : g_in
            assign w_seg_ext[g] = r_seg[g];
        end else begin : g_out
            assign w_seg_ext[g] = '0;
        end
    end

    // Select decode, write-first forwarding and inhibit counter next state
    always_comb begin
        w_wr_ok   = i_wr_en && in_rng(i_wr_sel);
        w_ss_wr   = w_wr_ok && (i_wr_sel == SEL_W'(SS_IDX));
        w_agu_sel = (i_agu_use_ovr && r_ovr_active) ? r_ovr_sel : i_agu_sel;
        w_rd_seg  = (w_wr_ok && i_wr_sel == i_rd_sel) ? i_wr_data : w_seg_ext[i_rd_sel];
        w_agu_seg = (w_wr_ok && i_wr_sel == w_agu_sel) ? i_wr_data : w_seg_ext[w_agu_sel];
        w_sel_err = (i_wr_en && !in_rng(i_wr_sel)) || (i_rd_en && !in_rng(i_rd_sel)) ||
                    (i_agu_req && !in_rng(w_agu_sel)) || (i_ovr_set && !in_rng(i_ovr_sel));
        w_cnt_nxt = w_ss_wr ? 2'd2 : (i_inst_bnd && r_inh_cnt != 2'd0) ? r_inh_cnt - 2'd1 : r_inh_cnt;
    end

    seg_pa_adder #(.SEG_W(SEG_W), .OFF_W(OFF_W)) u_adder (
        .i_seg (w_agu_seg),
        .i_off (i_agu_off),
        .o_pa  (w_pa)
    );

    // Segment register storage; out-of-range writes never reach the bank
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (rst) r_seg[i] <= (i == CS_IDX) ? CS_RST : '0;
            else if (w_wr_ok && i_wr_sel == SEL_W'(i)) r_seg[i] <= i_wr_data;
        end
    end

    // Registered read/AGU results, override latch (set beats clear) and inhibit window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_pa          <= '0;
            r_pa_valid    <= 1'b0;
            r_ovr_active  <= 1'b0;
            r_ovr_sel     <= '0;
            r_inh_cnt     <= 2'd0;
            r_int_inhibit <= 1'b0;
            r_sel_err     <= 1'b0;
        end else begin
            if (i_rd_en) r_rd_data <= w_rd_seg;
            r_rd_valid <= i_rd_en;
            if (i_agu_req) r_pa <= w_pa;
            r_pa_valid <= i_agu_req;
            if (i_ovr_set) begin
                r_ovr_active <= 1'b1;
                r_ovr_sel    <= i_ovr_sel;
            end else if (i_inst_bnd) begin
                r_ovr_active <= 1'b0;
            end
            r_inh_cnt     <= w_cnt_nxt;
            r_int_inhibit <= (w_cnt_nxt != 2'd0);
            r_sel_err     <= w_sel_err;
        end
    end

    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;
    assign o_pa          = r_pa;
    assign o_pa_valid    = r_pa_valid;
    assign o_ovr_active  = r_ovr_active;
    assign o_int_inhibit = r_int_inhibit;
    assign o_sel_err     = r_sel_err;
endmodule
